// File: rtl/mrt_pkg.sv
// Shared MinRoot types: polynomial operand, exponent-sequencer states and default squaring count.
package mrt_pkg;

    localparam int PolyW       = 32;
    localparam int ExpSqrCount = 256;

    typedef logic [PolyW-1:0] poly_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SQR,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/poly_exp_seq.sv
// Square-and-reduce sequencer: drives datapath strobes and forwards exponent taps over valid/ready.
// Optional POLY_EXP_SEQ_ABORT_EN adds abort_i, which returns any active run to IDLE without done_o.
//
// state | meaning
// IDLE  | ready_o=1, waiting for start_i
// LOAD  | datapath loads x into the squarer
// SQR   | one squaring per cycle, tap captured on mul_o when exp_q[cnt] is set
// DRAIN | wait for the last tap to be consumed, then pulse done_o
module poly_exp_seq
    import mrt_pkg::*;
#(
    parameter int NumSqr  = ExpSqrCount,
    parameter int CntBits = $clog2(NumSqr + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  poly_t              x_i,
    input  logic [NumSqr:0]    exp_i,
`ifdef POLY_EXP_SEQ_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               ready_o,
    output logic               done_o,
    output poly_t              x_o,
    output logic               sel_x_o,
    output logic               adv_sqr_o,
    output logic               adv_mul_o,
    output logic               mul_valid_o,
    input  logic               mul_ready_i,
    output logic [CntBits-1:0] tap_idx_o
);

    seq_state_e         state_q, state_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic [NumSqr:0]    exp_q, exp_d;
    poly_t              x_q, x_d;
    logic               mul_valid_q, mul_valid_d;
    logic [CntBits-1:0] tap_idx_q, tap_idx_d;
    logic               done_q, done_d;
    logic               tap, stall;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        x_d         = x_q;
        mul_valid_d = mul_valid_q;
        tap_idx_d   = tap_idx_q;
        done_d      = 1'b0;
        sel_x_o     = 1'b0;
        adv_sqr_o   = 1'b0;
        adv_mul_o   = 1'b0;
        tap         = 1'b0;
        stall       = 1'b0;

        if (mul_valid_q && mul_ready_i) begin
            mul_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = x_i;
                    exp_d   = exp_i;
                    cnt_d   = CntBits'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sel_x_o   = 1'b1;
                adv_sqr_o = 1'b1;
                state_d   = SQR;
            end
            SQR: begin
                tap   = exp_q[cnt_q];
                // Only a tap can stall: it would overwrite an unconsumed mul_o.
                stall = tap && mul_valid_q && !mul_ready_i;
                if (!stall) begin
                    adv_sqr_o = 1'b1;
                    adv_mul_o = tap;
                    if (tap) begin
                        mul_valid_d = 1'b1;
                        tap_idx_d   = cnt_q;
                    end
                    cnt_d = cnt_q + CntBits'(1);
                    if (cnt_q == CntBits'(NumSqr)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!mul_valid_q || mul_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef POLY_EXP_SEQ_ABORT_EN
        if (abort_i && state_q != IDLE) begin
            state_d     = IDLE;
            sel_x_o     = 1'b0;
            adv_sqr_o   = 1'b0;
            adv_mul_o   = 1'b0;
            mul_valid_d = 1'b0;
            tap_idx_d   = tap_idx_q;
            done_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exp_q       <= '0;
            x_q         <= '0;
            mul_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            x_q         <= x_d;
            mul_valid_q <= mul_valid_d;
            tap_idx_q   <= tap_idx_d;
            done_q      <= done_d;
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign done_o      = done_q;
    assign x_o         = x_q;
    assign mul_valid_o = mul_valid_q;
    assign tap_idx_o   = tap_idx_q;

endmodule
